axis_frame_buffer_tx: RTL
=========================

Name: axis_frame_buffer_tx

Overview:
- Single-clock frame transmitter: software/host logic fills an internal word buffer, then issues a length command; the block streams the frame out as AXI4-Stream with tkeep/tlast/tuser.
- Output feeds the s_ side of the team's async FIFO adapter, e.g. the Ethernet TX path toward the MAC clock domain.
- It is the producing end of the frame stream that the FIFO/adapter consumes.

Parameters:
- DATA_WIDTH, 64, output tdata width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; byte granularity.
- BUF_WORDS, 256, buffer depth in DATA_WIDTH words; power of 2.
- ADDR_WIDTH, $clog2(BUF_WORDS), buffer word address width.
- LEN_WIDTH, $clog2(BUF_WORDS*KEEP_WIDTH)+1, byte-length field width.
- USER_WIDTH, 1, tuser width; bit 0 is the bad-frame marker.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_WIDTH  buffer word address.
- wr_data  in  DATA_WIDTH  buffer write data.
- wr_ready  out  1  write accepted when high (equals IDLE).
- cmd_valid  in  1  send command valid.
- cmd_ready  out  1  command accepted on cmd_valid&&cmd_ready.
- cmd_len  in  LEN_WIDTH  frame length in bytes, starting at word 0 byte 0.
- cmd_bad  in  1  mark frame bad (tuser[0]=1 on last beat).
- m_axis_tdata  out  DATA_WIDTH  stream data; byte 0 = bits 7:0.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  USER_WIDTH  bad-frame marker on last beat, else 0.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after last beat handshake.
- error_len  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset values: m_axis_tvalid=0, tlast=0, tkeep=0, tuser=0, tdata=0, busy=0, done=0, error_len=0, cmd_ready=1, wr_ready=1.
- Buffer RAM contents are not cleared by reset.

Buffer and commands:
- Buffer is single-port synchronous-read RAM with a write port active only in IDLE.
- wr_en while wr_ready=0 is ignored, with no error.
- A write in the same cycle as command accept commits before the first read.
- States: IDLE -> SEND -> IDLE.
- IDLE: cmd_ready=1.
- On accept with cmd_len==0 or cmd_len>BUF_WORDS*KEEP_WIDTH: pulse error_len next cycle, stay IDLE, no beats.
- Otherwise latch len and bad, set nwords=ceil(len/KEEP_WIDTH), enter SEND, set busy=1.

SEND state:
- Reads words 0..nwords-1 in order.
- A 2-entry output stage hides RAM latency.
- First tvalid is 2 cycles after command accept.
- With tready held high, throughput is 1 beat/cycle with no bubbles.

Beat contents:
- Non-last beats: tkeep all ones, tlast=0, tuser=0.
- Last beat: tlast=1, tuser[0]=bad.
- Last beat tkeep = low (len mod KEEP_WIDTH) bits set, or all ones if the remainder is 0.
- Last beat bytes with tkeep=0 are driven as zero.

AXIS rules:
- Once tvalid=1, tdata/tkeep/tlast/tuser are held stable and tvalid does not drop until handshake.
- The only exception is rst, which drops tvalid the next cycle and discards the frame.

Completion:
- On the last-beat handshake, the next cycle has done=1, busy=0, state IDLE, cmd_ready=1.
- Back-to-back commands are allowed starting from that cycle.

Other rules:
- cmd_valid is not accepted while in SEND; cmd_ready=0.
- rst during SEND: next cycle all outputs at reset values and state IDLE; no done pulse.
- The address counter never wraps: a max-length frame ends at word BUF_WORDS-1.

Test Plan:
- Defaults; buffer word0=0x0706050403020100; cmd_len=8 -> one beat: tdata=0x0706050403020100, tkeep=0xFF, tlast=1, tuser=0; tvalid 2 cycles after accept; done 1 cycle after handshake.
- cmd_len=13, words 0/1 filled with 0x11.. -> 2 beats: tkeep 0xFF then 0x1F; beat 2 bytes 5-7 = 0x00; tlast only on beat 2.
- cmd_len=32, tready pattern 1,0,1,0... -> exactly 4 beats in order; signals stable during stalls; no duplicates; done after 4th handshake.
- cmd_len=0, then cmd_len=2049 -> error_len pulses each time; tvalid stays 0; cmd_ready stays 1.
- cmd_bad=1, cmd_len=16 -> tuser=0 on beat 1 and 1 on beat 2; second command cmd_bad=0 issued in the done cycle -> accepted, tuser=0 throughout.
- cmd_len=2048, tready=1 -> 256 consecutive beats with no gaps; writes attempted during SEND ignored (buffer readback unchanged).
- rst after beat 1 of a 24-byte frame -> tvalid=0 next cycle, cmd_ready=1; new cmd_len=8 sends one correct beat.

Source files
------------

// File: rtl/axis_frame_buffer_tx.sv
// rtl/axis_frame_buffer_tx.sv - word buffer streamed out as an AXI4-Stream frame on command
module axis_frame_buffer_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int BUF_WORDS  = 256,
  parameter int ADDR_WIDTH = $clog2(BUF_WORDS),
  parameter int LEN_WIDTH  = $clog2(BUF_WORDS * KEEP_WIDTH) + 1,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_bad,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic                  error_len
);

  // Word counters need one extra bit so a full buffer (BUF_WORDS words) is representable.
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(BUF_WORDS * KEEP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [BUF_WORDS];

  // Command decode
  logic                  cmd_fire;
  logic                  len_ok;
  logic                  start;
  logic                  wr_fire;
  logic [CNT_WIDTH-1:0]  cmd_nwords;
  logic [LEN_WIDTH-1:0]  cmd_rem;
  logic [KEEP_WIDTH-1:0] cmd_last_keep;

  // Frame context latched at command accept
  logic [CNT_WIDTH-1:0]  nwords_q;
  logic [KEEP_WIDTH-1:0] last_keep_q;
  logic                  bad_q;

  // RAM read stage: rd_idx_q is the next word to fetch, rd_vld_q marks rd_data_q as holding a word
  logic [CNT_WIDTH-1:0]  rd_idx_q;
  logic                  rd_vld_q;
  logic                  rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_last_d;
  logic                  rd_fwd;
  logic                  more_words;

  // Two-entry output stage; entry 0 drives the stream, entry 1 is zero whenever unused
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [KEEP_WIDTH-1:0] e0_keep_q, e0_keep_d, e1_keep_q, e1_keep_d;
  logic                  e0_last_q, e0_last_d, e1_last_q, e1_last_d;
  logic                  out_pop;
  logic                  out_push;
  logic                  push_slot0;
  logic [DATA_WIDTH-1:0] new_data;
  logic [KEEP_WIDTH-1:0] new_keep;

  logic                  done_q;
  logic                  err_q;

  assign cmd_fire   = cmd_valid && (state_q == S_IDLE);
  assign wr_fire    = wr_en && (state_q == S_IDLE);
  assign len_ok     = (cmd_len != '0) && (cmd_len <= MAX_LEN);
  assign start      = cmd_fire && len_ok;
  assign cmd_nwords = CNT_WIDTH'((cmd_len + (KEEP_LEN - LEN_WIDTH'(1))) / KEEP_LEN);
  assign cmd_rem    = cmd_len % KEEP_LEN;

  // Byte enables of the final beat: the low remainder bytes, or the whole word when the length is word aligned
  always_comb begin
    cmd_last_keep = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      cmd_last_keep[b] = (cmd_rem == '0) || (LEN_WIDTH'(b) < cmd_rem);
    end
  end

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign out_pop       = m_axis_tvalid && m_axis_tready;
  assign out_push      = rd_vld_q && ((cnt_q != 2'd2) || out_pop);
  assign more_words    = (rd_idx_q < nwords_q);

  // Word 0 is fetched at the accept edge so the first beat is presented two cycles after accept.
  // A write to word 0 in that same cycle is forwarded so it is seen by the frame.
  assign rd_en     = start || ((state_q == S_SEND) && more_words && (!rd_vld_q || out_push));
  assign rd_addr   = start ? '0 : rd_idx_q[ADDR_WIDTH-1:0];
  assign rd_last_d = start ? (cmd_nwords == CNT_WIDTH'(1)) : (rd_idx_q == (nwords_q - CNT_WIDTH'(1)));
  assign rd_fwd    = start && wr_fire && (wr_addr == '0);

  // Buffer RAM: write port open only while idle, synchronous read; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= rd_fwd ? wr_data : mem[rd_addr];
    end
  end

  // Frame context, read-stage bookkeeping and the done/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      nwords_q    <= '0;
      last_keep_q <= '0;
      bad_q       <= 1'b0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= out_pop && e0_last_q;
      err_q  <= cmd_fire && !len_ok;
      if (start) begin
        nwords_q    <= cmd_nwords;
        last_keep_q <= cmd_last_keep;
        bad_q       <= cmd_bad;
        rd_idx_q    <= CNT_WIDTH'(1);
      end else if (rd_en) begin
        rd_idx_q <= rd_idx_q + CNT_WIDTH'(1);
      end
      if (rd_en) begin
        rd_vld_q  <= 1'b1;
        rd_last_q <= rd_last_d;
      end else if (out_push) begin
        rd_vld_q <= 1'b0;
      end
    end
  end

  // Shape the word leaving the read stage: full keep except on the last word, unused bytes zeroed
  always_comb begin
    new_keep = rd_last_q ? last_keep_q : '1;
    new_data = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      new_data[8*b +: 8] = new_keep[b] ? rd_data_q[8*b +: 8] : 8'h00;
    end
  end

  // Output stage shift/fill: pop moves entry 1 forward, push lands in the first free slot after the pop
  always_comb begin
    cnt_d     = cnt_q + 2'(out_push) - 2'(out_pop);
    e0_data_d = e0_data_q;
    e0_keep_d = e0_keep_q;
    e0_last_d = e0_last_q;
    e1_data_d = e1_data_q;
    e1_keep_d = e1_keep_q;
    e1_last_d = e1_last_q;
    push_slot0 = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && out_pop);
    if (out_pop) begin
      e0_data_d = e1_data_q;
      e0_keep_d = e1_keep_q;
      e0_last_d = e1_last_q;
      e1_data_d = '0;
      e1_keep_d = '0;
      e1_last_d = 1'b0;
    end
    if (out_push) begin
      if (push_slot0) begin
        e0_data_d = new_data;
        e0_keep_d = new_keep;
        e0_last_d = rd_last_q;
      end else begin
        e1_data_d = new_data;
        e1_keep_d = new_keep;
        e1_last_d = rd_last_q;
      end
    end
  end

  // Output stage registers; reset discards any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 2'd0;
      e0_data_q <= '0;
      e0_keep_q <= '0;
      e0_last_q <= 1'b0;
      e1_data_q <= '0;
      e1_keep_q <= '0;
      e1_last_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      e0_data_q <= e0_data_d;
      e0_keep_q <= e0_keep_d;
      e0_last_q <= e0_last_d;
      e1_data_q <= e1_data_d;
      e1_keep_q <= e1_keep_d;
      e1_last_q <= e1_last_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded handshake/status outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        wr_ready  = 1'b1;
        if (cmd_valid && len_ok) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy = 1'b1;
        if (out_pop && e0_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_axis_tdata = e0_data_q;
  assign m_axis_tkeep = e0_keep_q;
  assign m_axis_tlast = e0_last_q;
  assign m_axis_tuser = USER_WIDTH'(e0_last_q && bad_q);
  assign done         = done_q;
  assign error_len    = err_q;

endmodule
